// File: rtl/proc_io_pkg.sv
// Shared types and constants for the processor I/O scheduler: FSM states,
// error flag bit positions and default parameter values.
package proc_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int ERR_UFL0 = 0;
    localparam int ERR_UFL1 = 1;
    localparam int ERR_WDOG = 2;

    localparam int DW_DEF       = 32;
    localparam int DEPTH_DEF    = 4;
    localparam int NOUT_DEF     = 5;
    localparam int WDOG_CYC_DEF = 1024;

endpackage

// File: rtl/proc_io_fifo.sv
// Per-channel sample FIFO: head visible combinationally, pop takes effect at the edge.
// Latency: a push is visible at the head one cycle later; full blocks pushes, empty ignores pops.
module proc_io_fifo
    import proc_io_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_dat_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push_ok, pop_ok;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/proc_io_sched.sv
// Two-channel sample scheduler feeding a processor frame by frame (IDLE/FIRE/RUN/DONE).
// Latency: itr one cycle after both FIFOs hold data; in_proc is combinational from the FIFO head.
// Backpressure: sN_ready drops when FIFO N is full; optional watchdog via PROC_IO_SCHED_WDOG_EN.
module proc_io_sched
    import proc_io_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NOUT     = NOUT_DEF,
    parameter int WDOG_CYC = WDOG_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst_geral_n,
    input  logic [DW-1:0]   s0_data,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [DW-1:0]   s1_data,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [1:0]      req_in,
    output logic [DW-1:0]   in_proc,
    input  logic [NOUT-1:0] out_en,
    output logic            itr,
    output logic            frame_done,
    output logic [15:0]     frame_cnt,
    output logic [2:0]      err
);

    state_e        state_q, state_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]    ufl_q, ufl_d;
    logic          full0, full1, empty0, empty1;
    logic [DW-1:0] head0, head1;
    logic          sel0, sel1, pop0, pop1;
    logic          wdog_to, wdog_err;
    logic          eof;

    assign eof = out_en[NOUT-1];

    // Ready is held low while reset is asserted, not just when full.
    assign s0_ready = !full0 && rst_geral_n;
    assign s1_ready = !full1 && rst_geral_n;

    proc_io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
        .clk        (clk),
        .rst_n      (rst_geral_n),
        .push_i     (s0_valid && s0_ready),
        .push_dat_i (s0_data),
        .pop_i      (pop0),
        .head_dat_o (head0),
        .full_o     (full0),
        .empty_o    (empty0)
    );

    proc_io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
        .clk        (clk),
        .rst_n      (rst_geral_n),
        .push_i     (s1_valid && s1_ready),
        .push_dat_i (s1_data),
        .pop_i      (pop1),
        .head_dat_o (head1),
        .full_o     (full1),
        .empty_o    (empty1)
    );

    assign sel0 = (state_q == ST_RUN) && (req_in == 2'b01);
    assign sel1 = (state_q == ST_RUN) && (req_in == 2'b10);
    assign pop0 = sel0 && !empty0;
    assign pop1 = sel1 && !empty1;

    always_comb begin
        in_proc = '0;
        if (pop0)      in_proc = head0;
        else if (pop1) in_proc = head1;
    end

`ifdef PROC_IO_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          wdog_err_q, wdog_err_d;

    // Counter restarts in FIRE so every RUN period gets the full budget.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == ST_FIRE)     wdog_d = '0;
        else if (state_q == ST_RUN) wdog_d = wdog_q + WW'(1);
    end

    assign wdog_to    = (state_q == ST_RUN) && (wdog_q == WW'(WDOG_CYC - 1)) && !eof;
    assign wdog_err_d = wdog_err_q || wdog_to;
    assign wdog_err   = wdog_err_q;

    always_ff @(posedge clk or negedge rst_geral_n) begin
        if (!rst_geral_n) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_d;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYC;
    assign wdog_to     = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    // Only the end-of-frame strobe matters; the other processor strobes are not used here.
    logic unused_out_en;
    assign unused_out_en = ^out_en[NOUT-2:0];

    always_comb begin
        state_d     = state_q;
        itr         = 1'b0;
        frame_done  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        ufl_d       = ufl_q | {sel1 && empty1, sel0 && empty0};
        case (state_q)
            ST_IDLE: if (!empty0 && !empty1) state_d = ST_FIRE;
            ST_FIRE: begin
                itr     = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (eof)          state_d = ST_DONE;
                else if (wdog_to) state_d = ST_IDLE;
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_geral_n) begin
        if (!rst_geral_n) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            ufl_q       <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            ufl_q       <= ufl_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

    always_comb begin
        err           = '0;
        err[ERR_UFL0] = ufl_q[0];
        err[ERR_UFL1] = ufl_q[1];
        err[ERR_WDOG] = wdog_err;
    end

endmodule

// File: tb/tb_proc_io_sched.sv
// Scoreboard bench for proc_io_sched: frame flow, FIFO full/underflow, watchdog, resets, counter wrap.
module tb_proc_io_sched;

    localparam int DW   = 32;
    localparam int NOUT = 5;

    logic            clk = 1'b0;
    logic            rst_geral_n;
    logic [DW-1:0]   s0_data, s1_data;
    logic            s0_valid, s1_valid, s0_ready, s1_ready;
    logic [1:0]      req_in;
    logic [DW-1:0]   in_proc;
    logic [NOUT-1:0] out_en;
    logic            itr, frame_done;
    logic [15:0]     frame_cnt;
    logic [2:0]      err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [15:0]   exp_cnt = 16'd0;
    logic [2:0]    exp_err = 3'b000;

    proc_io_sched #(.DW(DW), .DEPTH(4), .NOUT(NOUT), .WDOG_CYC(16)) dut (
        .clk        (clk),
        .rst_geral_n(rst_geral_n),
        .s0_data    (s0_data),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s1_data    (s1_data),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .req_in     (req_in),
        .in_proc    (in_proc),
        .out_en     (out_en),
        .itr        (itr),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pushes samples from IDLE and walks through FIRE into RUN.
    task automatic start_frame(input bit push0, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        s0_valid = push0; s0_data = d0;
        s1_valid = 1'b1;  s1_data = d1;
        #1;
        checks++;
        if ((push0 && !s0_ready) || !s1_ready) begin
            errors++; $display("FAIL start_ready: s0_ready=%0b s1_ready=%0b required 1", s0_ready, s1_ready);
        end
        if (push0) q0.push_back(d0);
        q1.push_back(d1);
        cyc();
        s0_valid = 1'b0; s1_valid = 1'b0;
        checks++;
        if (itr !== 1'b0) begin errors++; $display("FAIL itr_early: itr=%0b required 0", itr); end
        cyc();
        checks++;
        if (itr !== 1'b1) begin errors++; $display("FAIL itr_pulse: itr=%0b required 1", itr); end
        cyc();
        checks++;
        if (itr !== 1'b0) begin errors++; $display("FAIL itr_single: itr=%0b required 0", itr); end
    endtask

    task automatic pop_ch(input int ch);
        logic [DW-1:0] exp;
        req_in = (ch == 0) ? 2'b01 : 2'b10;
        #1;
        exp = (ch == 0) ? q0.pop_front() : q1.pop_front();
        checks++;
        if (in_proc !== exp) begin
            errors++; $display("FAIL pop_ch%0d: in_proc=%h required %h", ch, in_proc, exp);
        end
        cyc();
        req_in = 2'b00;
    endtask

    task automatic end_frame();
        req_in = 2'b00;
        out_en = 5'b10000;
        #1;
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL done_early: frame_done=%0b required 0", frame_done); end
        cyc();
        out_en = '0;
        checks++;
        if (frame_done !== 1'b1 || frame_cnt !== exp_cnt) begin
            errors++; $display("FAIL done_pulse: frame_done=%0b cnt=%h required 1 cnt=%h", frame_done, frame_cnt, exp_cnt);
        end
        cyc();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (frame_done !== 1'b0 || frame_cnt !== exp_cnt) begin
            errors++; $display("FAIL done_after: frame_done=%0b cnt=%h required 0 cnt=%h", frame_done, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_geral_n = 1'b0;
        s0_valid = 0; s1_valid = 0; s0_data = '0; s1_data = '0;
        req_in = 2'b00; out_en = '0;
        #3;
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || in_proc !== '0 || itr !== 1'b0 ||
            frame_done !== 1'b0 || frame_cnt !== 16'd0 || err !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: rdy=%b%b in=%h itr=%b done=%b cnt=%h err=%b required all 0",
                     s0_ready, s1_ready, in_proc, itr, frame_done, frame_cnt, err);
        end
        cyc(); cyc();
        rst_geral_n = 1'b1;
        #1;
        checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: %b%b required 11", s0_ready, s1_ready);
        end
        cyc();
    endtask

    task automatic test_basic_frame();
        start_frame(1'b1, 32'h11, 32'h22);
        pop_ch(0);
        pop_ch(1);
        end_frame();
    endtask

    task automatic test_eof_outside_run();
        out_en = 5'b10000;
        cyc(); cyc();
        checks++;
        if (frame_done !== 1'b0 || frame_cnt !== exp_cnt || itr !== 1'b0) begin
            errors++; $display("FAIL eof_idle: done=%b cnt=%h itr=%b required 0 %h 0", frame_done, frame_cnt, itr, exp_cnt);
        end
        out_en = '0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            s0_valid = 1'b1; s0_data = 32'h40 + i;
            #1;
            checks++;
            if (s0_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: s0_ready=%b required 1", i, s0_ready); end
            q0.push_back(s0_data);
            cyc();
        end
        s0_data = 32'h55;
        checks++;
        if (s0_ready !== 1'b0) begin errors++; $display("FAIL full_ready: s0_ready=%b required 0", s0_ready); end
        cyc();
        s0_valid = 1'b0;
        start_frame(1'b0, '0, 32'h99);
        pop_ch(0);
        // Push and pop on the same cycle with three entries held.
        s0_valid = 1'b1; s0_data = 32'h66; req_in = 2'b01;
        #1;
        checks++;
        if (s0_ready !== 1'b1 || in_proc !== q0[0]) begin
            errors++; $display("FAIL push_pop: ready=%b in_proc=%h required 1 %h", s0_ready, in_proc, q0[0]);
        end
        void'(q0.pop_front());
        q0.push_back(32'h66);
        cyc();
        s0_valid = 1'b0; req_in = 2'b00;
        for (int i = 0; i < 3; i++) pop_ch(0);
        pop_ch(1);
        end_frame();
    endtask

    task automatic test_underflow();
        start_frame(1'b1, 32'hA0, 32'hB0);
        pop_ch(0);
        req_in = 2'b01;
        #1;
        checks++;
        if (in_proc !== '0) begin errors++; $display("FAIL ufl_data: in_proc=%h required 0", in_proc); end
        cyc();
        exp_err[0] = 1'b1;
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL ufl_err: err=%b required %b", err, exp_err); end
        req_in = 2'b11;
        #1;
        checks++;
        if (in_proc !== '0) begin errors++; $display("FAIL req11: in_proc=%h required 0", in_proc); end
        cyc();
        pop_ch(1);
        out_en = 5'b01111;
        cyc();
        out_en = '0;
        cyc();
        checks++;
        if (frame_done !== 1'b0 || frame_cnt !== exp_cnt) begin
            errors++; $display("FAIL low_out_en: done=%b cnt=%h required 0 %h", frame_done, frame_cnt, exp_cnt);
        end
        end_frame();
    endtask

    task automatic test_wdog();
        start_frame(1'b1, 32'hC0, 32'hD0);
        pop_ch(0);
        pop_ch(1);
`ifdef PROC_IO_SCHED_WDOG_EN
        repeat (13) cyc();
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL wdog_early: err=%b required %b", err, exp_err); end
        cyc();
        exp_err[2] = 1'b1;
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL wdog_fire: err=%b required %b", err, exp_err); end
        out_en = 5'b10000;
        cyc();
        out_en = '0;
        checks++;
        if (frame_done !== 1'b0 || frame_cnt !== exp_cnt) begin
            errors++; $display("FAIL wdog_idle: done=%b cnt=%h required 0 %h", frame_done, frame_cnt, exp_cnt);
        end
        cyc();
`else
        repeat (40) cyc();
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL no_wdog: err=%b required %b", err, exp_err); end
        end_frame();
`endif
    endtask

    task automatic test_reset_mid();
        start_frame(1'b1, 32'hE0, 32'hF0);
        req_in = 2'b01;
        rst_geral_n = 1'b0;
        #1;
        checks++;
        if (in_proc !== '0 || s0_ready !== 1'b0 || err !== 3'b000 || frame_cnt !== 16'd0 ||
            frame_done !== 1'b0 || itr !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: in=%h rdy=%b err=%b cnt=%h done=%b itr=%b required 0",
                     in_proc, s0_ready, err, frame_cnt, frame_done, itr);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done%0d: frame_done=%b required 0", i, frame_done); end
        end
        req_in = 2'b00;
        rst_geral_n = 1'b1;
        q0.delete(); q1.delete();
        exp_cnt = 16'd0; exp_err = 3'b000;
        cyc();
        start_frame(1'b1, 32'h12, 32'h34);
        pop_ch(0);
        pop_ch(1);
        end_frame();
    endtask

    task automatic test_wrap();
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        #1;
        exp_cnt = 16'hFFFF;
        checks++;
        if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL preset: cnt=%h required ffff", frame_cnt); end
        cyc();
        start_frame(1'b1, 32'h77, 32'h88);
        pop_ch(0);
        pop_ch(1);
        end_frame();
        checks++;
        if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap: cnt=%h required 0000", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_eof_outside_run();
        test_full();
        test_underflow();
        test_wdog();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
